tape_byte_encoder: RTL

- Downstream of the cassette SDRAM reader. Accepts one tape byte per start pulse and serialises it into the Oric tape frame: start bit, 8 data bits LSB first, odd parity, and stop bits.
- Each bit is emitted as an FSK square-wave cycle on dout, which feeds the VIA tape input.
- Handshake is start/done, so the reader can advance to the next byte as soon as done pulses.

---
 rtl/tape_pkg.sv | 63 ++++++
 rtl/tape_phase_timer.sv | 54 +++++
 rtl/tape_byte_encoder.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tape_pkg.sv
// -----------------------------------------------------------------------------
// tape_pkg
//   Shared definitions for the Oric tape byte encoder:
//     - tape_state_e : encoder FSM states (IDLE/HIGH/LOW/FIN)
//     - DEF_*        : default half-cycle lengths and stop-bit count
//     - FW()         : frame width for a given number of stop bits
//     - odd_parity() : parity bit that makes data+parity hold an odd count of ones
//     - cnt_width()  : counter width helper (never returns less than 1)
//     - max3()       : largest of three cycle counts
// -----------------------------------------------------------------------------
package tape_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    FIN  = 2'd3
  } tape_state_e;

  localparam int unsigned DEF_HI_CYC    = 32'd5000;
  localparam int unsigned DEF_LO1_CYC   = 32'd5000;
  localparam int unsigned DEF_LO0_CYC   = 32'd10000;
  localparam int unsigned DEF_STOP_BITS = 32'd4;

  // Start bit + 8 data bits + parity + stop bits.
  function automatic int unsigned FW(input int unsigned stop_bits);
    return 32'd10 + stop_bits;
  endfunction

  // XNOR-reduce: the returned bit brings the total number of ones to odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Bits needed to hold values up to max_val-1; a 1-bit minimum keeps
  // degenerate parameterisations from producing zero-width vectors.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(max_val);
    end
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage : tape_pkg

// File: rtl/tape_phase_timer.sv
// -----------------------------------------------------------------------------
// tape_phase_timer
//   Loadable down counter that times one half of a tape bit cycle.
//   Priority: clr > load > dec. Decrement saturates at zero; the encoder
//   always reloads at zero so the saturation never matters in normal use.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous clear to zero
//   load         : load load_val
//   dec          : count down by one
//   load_val     : reload value (cycles - 1)
//   zero         : counter currently at zero
// -----------------------------------------------------------------------------
module tape_phase_timer #(
  parameter int unsigned W = 32'd14
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next counter value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule : tape_phase_timer

// File: rtl/tape_byte_encoder.sv
// -----------------------------------------------------------------------------
// tape_byte_encoder
//   Serialises one byte per start pulse into an Oric tape frame
//   {STOP_BITS x '1', parity, din[7:0], '0'} sent LSB first. Every bit is one
//   FSK square-wave cycle on dout: a high half of HI_CYC clocks followed by a
//   low half of LO1_CYC ('1') or LO0_CYC ('0') clocks. A single-cycle done
//   pulse (FIN state) marks completion; abort cancels silently.
//
//   Optional build macro TAPE_SLOW_EN adds the 'slow' input (sampled with
//   start). With slow=1 a '1' bit is 8 cycles of HI_CYC/LO1_CYC halves and a
//   '0' bit is 4 cycles of 2*HI_CYC/LO0_CYC halves. Without the macro only the
//   fast format exists and no repeat counter is built.
//
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   start    : single-cycle request, din (and slow) sampled on this cycle
//   slow     : (TAPE_SLOW_EN only) select slow format for this frame
//   din      : byte to encode
//   abort    : synchronous cancel of the frame in progress
//   busy     : frame in progress (registered)
//   done     : one-cycle completion pulse (registered)
//   dout     : tape waveform (registered)
//
// Parameters: HI_CYC, LO1_CYC, LO0_CYC half-cycle lengths in clocks (>= 1);
//             STOP_BITS number of trailing '1' bits, legal range 1..7.
// -----------------------------------------------------------------------------
module tape_byte_encoder #(
  parameter int unsigned HI_CYC    = tape_pkg::DEF_HI_CYC,
  parameter int unsigned LO1_CYC   = tape_pkg::DEF_LO1_CYC,
  parameter int unsigned LO0_CYC   = tape_pkg::DEF_LO0_CYC,
  parameter int unsigned STOP_BITS = tape_pkg::DEF_STOP_BITS
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
`ifdef TAPE_SLOW_EN
  input  logic       slow,
`endif
  input  logic [7:0] din,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       dout
);

  import tape_pkg::*;

  localparam int unsigned FRAME_W = FW(STOP_BITS);
`ifdef TAPE_SLOW_EN
  localparam int unsigned HI_LONG_CYC = 32'd2 * HI_CYC;
`else
  localparam int unsigned HI_LONG_CYC = HI_CYC;
`endif
  localparam int unsigned MAX_CYC = max3(HI_LONG_CYC, LO1_CYC, LO0_CYC);
  localparam int unsigned CNT_W   = cnt_width(MAX_CYC);
  localparam int unsigned IDX_W   = cnt_width(FRAME_W);

  // Reload values are length-1 because the zero cycle is part of the phase.
  localparam logic [CNT_W-1:0] HI_RLD  = CNT_W'(HI_CYC - 32'd1);
  localparam logic [CNT_W-1:0] LO1_RLD = CNT_W'(LO1_CYC - 32'd1);
  localparam logic [CNT_W-1:0] LO0_RLD = CNT_W'(LO0_CYC - 32'd1);
`ifdef TAPE_SLOW_EN
  localparam logic [CNT_W-1:0] HI_LONG_RLD = CNT_W'(HI_LONG_CYC - 32'd1);
  // Extra square-wave repeats after the first one, per bit value.
  localparam logic [2:0]       REP_ONE     = 3'd7;
  localparam logic [2:0]       REP_ZERO    = 3'd3;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_W - 32'd1);

  tape_state_e          state_q;
  tape_state_e          state_d;
  logic [FRAME_W-1:0]   shift_q;
  logic [FRAME_W-1:0]   shift_d;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     idx_d;
  logic                 busy_q;
  logic                 busy_d;
  logic                 done_q;
  logic                 done_d;
  logic                 dout_q;
  logic                 dout_d;
`ifdef TAPE_SLOW_EN
  logic                 slow_q;
  logic                 slow_d;
  logic [2:0]           rep_q;
  logic [2:0]           rep_d;
`endif

  logic                 tmr_clr;
  logic                 tmr_load;
  logic                 tmr_dec;
  logic [CNT_W-1:0]     tmr_val;
  logic                 tmr_zero;

  tape_phase_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // FSM next state, frame shifter and timer control.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
`ifdef TAPE_SLOW_EN
    slow_d   = slow_q;
    rep_d    = rep_q;
`endif
    case (state_q)
      IDLE: begin
        tmr_clr = 1'b1;
        // abort has priority: a simultaneous start is dropped.
        if (start && !abort) begin
          state_d  = HIGH;
          shift_d  = {{STOP_BITS{1'b1}}, odd_parity(din), din, 1'b0};
          idx_d    = '0;
          tmr_clr  = 1'b0;
          tmr_load = 1'b1;
`ifdef TAPE_SLOW_EN
          // First bit is the '0' start bit.
          slow_d   = slow;
          tmr_val  = slow ? HI_LONG_RLD : HI_RLD;
          rep_d    = slow ? REP_ZERO : 3'd0;
`else
          tmr_val  = HI_RLD;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      HIGH: begin
        if (abort) begin
          state_d = IDLE;
          tmr_clr = 1'b1;
        end else if (tmr_zero) begin
          state_d  = LOW;
          tmr_load = 1'b1;
          tmr_val  = shift_q[0] ? LO1_RLD : LO0_RLD;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      LOW: begin
        if (abort) begin
          state_d = IDLE;
          tmr_clr = 1'b1;
        end else if (tmr_zero) begin
`ifdef TAPE_SLOW_EN
          // Slow format: repeat the same bit before moving on.
          if (rep_q != 3'd0) begin
            rep_d    = rep_q - 3'd1;
            state_d  = HIGH;
            tmr_load = 1'b1;
            tmr_val  = (slow_q && !shift_q[0]) ? HI_LONG_RLD : HI_RLD;
          end else
`endif
          if (idx_q == LAST_IDX) begin
            state_d = FIN;
            tmr_clr = 1'b1;
          end else begin
            state_d  = HIGH;
            shift_d  = {1'b0, shift_q[FRAME_W-1:1]};
            idx_d    = idx_q + IDX_W'(1);
            tmr_load = 1'b1;
`ifdef TAPE_SLOW_EN
            tmr_val  = (slow_q && !shift_q[1]) ? HI_LONG_RLD : HI_RLD;
            rep_d    = slow_q ? (shift_q[1] ? REP_ONE : REP_ZERO) : 3'd0;
`else
            tmr_val  = HI_RLD;
`endif
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end

      FIN: begin
        // start here is ignored; the frame already reported done.
        state_d = IDLE;
        tmr_clr = 1'b1;
      end

      default: begin
        state_d = IDLE;
        tmr_clr = 1'b1;
      end
    endcase
  end

  // Outputs follow the state being entered so they are registered yet aligned.
  always_comb begin
    busy_d = (state_d == HIGH) || (state_d == LOW);
    done_d = (state_d == FIN);
    dout_d = (state_d == HIGH);
  end

  // State, frame and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
    end
  end

`ifdef TAPE_SLOW_EN
  // Slow-format mode flag and per-bit repeat counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slow_q <= 1'b0;
      rep_q  <= 3'd0;
    end else begin
      slow_q <= slow_d;
      rep_q  <= rep_d;
    end
  end
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign dout = dout_q;

endmodule : tape_byte_encoder
